nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nsa_pkg.sv | 12 +
 rtl/nibble_serial_adder_if.sv | 27 ++
 rtl/cla4_slice.sv | 25 ++
 rtl/nibble_serial_adder.sv | 104 ++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared FSM encoding and nibble width for nibble_serial_adder
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result bundle; sub exists only with NIBBLE_SERIAL_ADDER_SUBTRACT_EN
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder exposing every bit carry-out
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic [3:0] c
);

  logic [3:0] p;
  logic [3:0] g;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] is the carry out of bit i, flattened so no carry ripples
  assign c[0] = g[0] | (p[0] & c0);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c[2:0], c0};

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial adder; NIBBLE_SERIAL_ADDER_SUBTRACT_EN adds A-B via bus.sub
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(N);

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;
  logic               sub_sel;
  logic               last_nib;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic [NIBBLE_W-1:0] nib_c;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign nib_a    = a_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign nib_b    = b_q[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (idx == IDX_W'(N - 1));

  cla4_slice u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .c0 (carry_q),
    .s  (nib_s),
    .c  (nib_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (last_nib)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Subtraction is folded in at latch time: invert B and force the carry-in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= sub_sel ? ~bus.b : bus.b;
            carry_q <= sub_sel ? 1'b1 : bus.cin;
            idx     <= '0;
          end
        end
        ST_RUN: begin
          sum_q[int'(idx)*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry_q <= nib_c[3];
          idx     <= idx + 1'b1;
          if (last_nib) begin
            cout_q <= nib_c[3];
            ovf_q  <= nib_c[2] ^ nib_c[3];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
